tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-slot time-division demultiplexer: the receive-side counterpart of the team's 4:1 select mux. It takes a serial stream of W-bit samples tagged with a frame-sync marker, assigns successive samples to slots 0..3 with an internal slot counter, and presents each completed frame as one 4-slot parallel word through a valid/ready handshake. It also flags framing errors and output overruns.

## Interface
- W, default 8: sample width in bits.
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- din, input, W: serial sample.
- din_valid, input, 1: din is present this cycle.
- din_sync, input, 1: marks the current sample as slot 0. Ignored when din_valid=0.
- dout, output, 4*W: assembled frame. Slot k is on dout[k*W +: W].
- dout_valid, output, 1: dout holds an unaccepted frame.
- dout_ready, input, 1: consumer accepts the frame on any cycle where dout_valid=1.
- frame_err, output, 1: one-cycle pulse on a framing violation.
- overrun, output, 1: one-cycle pulse when a completed frame is dropped.

## Operation
- Internal state: FSM {HUNT, ASSEMBLE}; slot counter slot[1:0]; three W-bit staging registers for slots 0..2.
- Only cycles with din_valid=1 are "beats". Cycles with din_valid=0 change nothing, except the handshake.
- HUNT:
  - beat with sync=0: discarded, no error.
  - beat with sync=1: staged as slot 0; slot←1; go to ASSEMBLE.
- ASSEMBLE, slot=0:
  - beat with sync=1: staged as slot 0; slot←1.
  - beat with sync=0: frame_err pulse; go to HUNT; beat discarded.
- ASSEMBLE, slot=1 or 2:
  - beat with sync=0: staged as slot[slot]; slot increments.
  - beat with sync=1: frame_err pulse; partial frame discarded; beat restaged as slot 0; slot←1 (resync, stay in ASSEMBLE).
- ASSEMBLE, slot=3:
  - beat with sync=1: handled as the resync case above.
  - beat with sync=0: frame complete. Candidate = {din, stage2, stage1, stage0}; slot←0; stay in ASSEMBLE.
- Frame completion and the output register:
  - If dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle: dout←candidate; dout_valid←1.
  - If dout_valid=1 and dout_ready=0: candidate dropped; dout unchanged; overrun pulse.
- Handshake:
  - dout_valid=1 and dout_ready=1 with no completion in that cycle: dout_valid←0.
  - dout holds its last value after acceptance; it is not cleared.
- Stream back-pressure: none. din_valid is never stalled, and samples are never back-pressured.

## Timing
- Reset (asynchronous assert, takes effect immediately): state=HUNT, slot=0, staging=0, dout=0, dout_valid=0, frame_err=0, overrun=0.
- Reset release: synchronous to clk. The first beat can be taken on the first rising edge after deassert.
- All outputs are registered.
- Latency: dout/dout_valid update on the rising edge that samples the slot-3 beat. They are visible in the following cycle (1 cycle after the last sample).
- frame_err and overrun are high for exactly the one cycle after the offending edge. Otherwise they are 0.
- Maximum rate: one frame per 4 cycles (back-to-back beats). A consumer holding dout_ready=1 continuously never sees an overrun.
- Reset mid-frame: the partial frame and any pending dout are lost, and dout_valid drops immediately.
- Simultaneous completion and acceptance (dout_valid=1, dout_ready=1, slot-3 beat): the old frame is accepted, the new frame loads, dout_valid stays 1, and no overrun is flagged.

## Test plan
- Reset, then beats A0(sync),A1,A2,A3 on consecutive cycles with dout_ready=1 → next cycle dout=0xA3A2A1A0 (W=8), dout_valid=1; frame_err=overrun=0.
- Beats 11(sync),22,gap of 3 idle cycles,33,44 → dout=0x44332211, dout_valid asserted exactly once; idle cycles do not advance slot.
- In HUNT, beats 55,66 without sync, then 01(sync),02,03,04 → 55/66 discarded silently, dout=0x04030201, frame_err never pulses.
- Beats 10(sync),20, then 30 with sync=1, then 40,50,60 → frame_err pulses once after the third beat; dout=0x60504030.
- dout_ready=0; two back-to-back frames 0x01020304 and 0x05060708 → dout stays 0x01020304, overrun pulses once after the second frame's slot-3 beat; raising dout_ready then drops dout_valid.
- Assert rst_n=0 after two beats of a frame, release, send a full frame 0xDEADBEEF → outputs zero during reset, partial data absent, dout=0xDEADBEEF.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Stream-in / frame-out bundle for the four-slot TDM demultiplexer.
// master = sample source and frame consumer; slave = the demux itself.
interface tdm_demux4_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0]   din;
  logic           din_valid;
  logic           din_sync;
  logic [4*W-1:0] dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           frame_err;
  logic           overrun;

  modport master (
    output din, din_valid, din_sync, dout_ready,
    input  dout, dout_valid, frame_err, overrun
  );

  modport slave (
    input  din, din_valid, din_sync, dout_ready,
    output dout, dout_valid, frame_err, overrun
  );
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: stages sync-tagged serial samples into slots 0..3 and
// presents each completed frame as one parallel word with valid/ready, framing-error and overrun flags.
module tdm_demux4 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic [0:0] {StHunt, StAssemble} state_e;

  state_e         state_q;
  logic [1:0]     slot_q;
  logic [W-1:0]   stage0_q, stage1_q, stage2_q;
  logic [4*W-1:0] dout_q;
  logic           dout_valid_q;
  logic           frame_err_q;
  logic           overrun_q;

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      slot_q       <= 2'd0;
      stage0_q     <= '0;
      stage1_q     <= '0;
      stage2_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // A completion below overrides this when it reloads dout in the same cycle.
      if (dout_valid_q && bus.dout_ready) dout_valid_q <= 1'b0;

      if (bus.din_valid) begin
        unique case (state_q)
          StHunt: begin
            if (bus.din_sync) begin
              stage0_q <= bus.din;
              slot_q   <= 2'd1;
              state_q  <= StAssemble;
            end
          end
          StAssemble: begin
            if (slot_q == 2'd0) begin
              if (bus.din_sync) begin
                stage0_q <= bus.din;
                slot_q   <= 2'd1;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= StHunt;
              end
            end else if (bus.din_sync) begin
              // Early sync: drop the partial frame and restart on this sample.
              frame_err_q <= 1'b1;
              stage0_q    <= bus.din;
              slot_q      <= 2'd1;
            end else if (slot_q == 2'd3) begin
              slot_q <= 2'd0;
              if (!dout_valid_q || bus.dout_ready) begin
                dout_q       <= {bus.din, stage2_q, stage1_q, stage0_q};
                dout_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              if (slot_q == 2'd1) stage1_q <= bus.din;
              else                stage2_q <= bus.din;
              slot_q <= slot_q + 2'd1;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: expected frames are queued when their last sample is
// driven and popped by a monitor on every accepted handshake.
module tb_tdm_demux4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux4_if #(.W(W)) bus ();

  tdm_demux4 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [4*W-1:0] exp_q[$];
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int acc_cnt = 0;

  // Pre-edge sampling: pop and compare on each accepted frame, count flag pulses.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun) ov_cnt++;
      if (bus.dout_valid && bus.dout_ready) begin
        logic [4*W-1:0] e;
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got dout=%h, required no frame", bus.dout);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout !== e) begin
            errors++;
            $display("FAIL scoreboard_dout: got %h, required %h", bus.dout, e);
          end
        end
      end
    end
  end

  task automatic beat(input logic [W-1:0] d, input logic s);
    @(negedge clk);
    bus.din       = d;
    bus.din_sync  = s;
    bus.din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.din_sync  = 1'b0;
    end
  endtask

  task automatic frame(input logic [4*W-1:0] f, input logic expect_out);
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && expect_out) exp_q.push_back(f);
      beat(f[k*W +: W], k == 0);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    chk("reset_dout", 64'(bus.dout), 64'h0);
    chk("reset_valid", 64'(bus.dout_valid), 64'h0);
    chk("reset_ferr", 64'(bus.frame_err), 64'h0);
    chk("reset_ovr", 64'(bus.overrun), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.din = '0; bus.din_valid = 1'b0; bus.din_sync = 1'b0; bus.dout_ready = 1'b1;
    do_reset();
  endtask

  task automatic test_basic();
    int fe0 = fe_cnt, ov0 = ov_cnt;
    bus.dout_ready = 1'b1;
    frame(32'hA3A2A1A0, 1'b1);
    idle(1);
    chk("basic_dout", 64'(bus.dout), 64'hA3A2A1A0);
    chk("basic_valid", 64'(bus.dout_valid), 64'h1);
    chk("basic_flags", 64'({bus.frame_err, bus.overrun}), 64'h0);
    idle(2);
    chk("basic_valid_drop", 64'(bus.dout_valid), 64'h0);
    chk("basic_fe_ov", 64'(fe_cnt - fe0 + ov_cnt - ov0), 64'h0);
  endtask

  task automatic test_gap();
    int a0 = acc_cnt;
    beat(8'h11, 1'b1);
    beat(8'h22, 1'b0);
    idle(3);
    chk("gap_no_early_valid", 64'(bus.dout_valid), 64'h0);
    beat(8'h33, 1'b0);
    exp_q.push_back(32'h44332211);
    beat(8'h44, 1'b0);
    idle(1);
    chk("gap_dout", 64'(bus.dout), 64'h44332211);
    idle(3);
    chk("gap_accept_once", 64'(acc_cnt - a0), 64'h1);
  endtask

  task automatic test_hunt();
    int fe0;
    do_reset();
    fe0 = fe_cnt;
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    frame(32'h04030201, 1'b1);
    idle(1);
    chk("hunt_dout", 64'(bus.dout), 64'h04030201);
    idle(2);
    chk("hunt_no_ferr", 64'(fe_cnt - fe0), 64'h0);
  endtask

  task automatic test_resync();
    int fe0 = fe_cnt;
    beat(8'h10, 1'b1);
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b1);
    idle(1);
    chk("resync_ferr_pulse", 64'(bus.frame_err), 64'h1);
    beat(8'h40, 1'b0);
    beat(8'h50, 1'b0);
    exp_q.push_back(32'h60504030);
    beat(8'h60, 1'b0);
    idle(1);
    chk("resync_dout", 64'(bus.dout), 64'h60504030);
    idle(2);
    chk("resync_ferr_once", 64'(fe_cnt - fe0), 64'h1);
  endtask

  task automatic test_overrun();
    int ov0 = ov_cnt;
    bus.dout_ready = 1'b0;
    frame(32'h01020304, 1'b1);
    frame(32'h05060708, 1'b0);
    idle(1);
    chk("ovr_pulse", 64'(bus.overrun), 64'h1);
    idle(2);
    chk("ovr_dout_held", 64'(bus.dout), 64'h01020304);
    chk("ovr_valid_held", 64'(bus.dout_valid), 64'h1);
    chk("ovr_once", 64'(ov_cnt - ov0), 64'h1);
    bus.dout_ready = 1'b1;
    idle(1);
    chk("ovr_valid_drop", 64'(bus.dout_valid), 64'h0);
  endtask

  task automatic test_simultaneous();
    int ov0 = ov_cnt;
    bus.dout_ready = 1'b0;
    frame(32'hC3C2C1C0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back(32'hD3D2D1D0);
      beat(8'hD0 + 8'(k), k == 0);
      if (k == 3) bus.dout_ready = 1'b1;
    end
    idle(1);
    chk("simul_valid", 64'(bus.dout_valid), 64'h1);
    chk("simul_dout", 64'(bus.dout), 64'hD3D2D1D0);
    idle(2);
    chk("simul_no_ovr", 64'(ov_cnt - ov0), 64'h0);
  endtask

  task automatic test_back_to_back();
    int ov0 = ov_cnt, a0 = acc_cnt;
    bus.dout_ready = 1'b1;
    for (int f = 0; f < 4; f++) frame(32'($urandom), 1'b1);
    idle(3);
    chk("b2b_no_ovr", 64'(ov_cnt - ov0), 64'h0);
    chk("b2b_accepts", 64'(acc_cnt - a0), 64'h4);
  endtask

  task automatic test_reset_mid();
    beat(8'h99, 1'b1);
    beat(8'h98, 1'b0);
    do_reset();
    frame(32'hDEADBEEF, 1'b1);
    idle(1);
    chk("rstmid_dout", 64'(bus.dout), 64'hDEADBEEF);
    chk("rstmid_valid", 64'(bus.dout_valid), 64'h1);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_hunt();
    test_resync();
    test_overrun();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
